if_stage: RTL and testbench



---
 rtl/if_stage_pkg.sv | 18 +
 rtl/if_stage.sv | 168 ++++++++++++++++
 tb/tb_if_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: constants shared between the fetch stage and its neighbours.
//   RESET_PC        - address of the first fetch after reset
//   FS_TO_DS_BUS_WD - width of {inst, pc} handed to decode
//   BR_BUS_WD       - width of {br_stall, br_taken, br_target} from decode
//   npc_sel_e       - source of the next fetch address
package if_stage_pkg;

    localparam logic [31:0] RESET_PC        = 32'hBFC0_0000;
    localparam int unsigned FS_TO_DS_BUS_WD = 64;
    localparam int unsigned BR_BUS_WD       = 34;

    typedef enum logic [1:0] {
        NpcBrBuf,
        NpcBrTarget,
        NpcSeq
    } npc_sel_e;

endpackage

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of a 5-stage MIPS pipeline.
// A pre-IF part issues one outstanding request on an SRAM-like instruction
// port; the IF part waits for the data, holds it and hands it to decode.
// The branch delay slot is always delivered before the branch target.
//
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   ds_allowin         - decode can accept an instruction this cycle
//   br_bus             - {br_stall, br_taken, br_target} from decode
//   fs_to_ds_valid     - fetched instruction valid
//   fs_to_ds_bus       - {inst, pc}
//   inst_sram_*        - instruction port (read-only, word sized, 1 outstanding)
module if_stage
    import if_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_req,
    output logic                       inst_sram_wr,
    output logic [1:0]                 inst_sram_size,
    output logic [3:0]                 inst_sram_wstrb,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata
);

    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;

    assign {br_stall, br_taken, br_target} = br_bus;

    logic        req_q,         req_d;
    logic [31:0] req_pc_q,      req_pc_d;
    logic [31:0] seq_pc_q,      seq_pc_d;
    logic [31:0] fs_pc_q,       fs_pc_d;
    logic        fs_valid_q,    fs_valid_d;
    logic        fs_waiting_q,  fs_waiting_d;
    logic [31:0] fs_inst_q,     fs_inst_d;
    logic        buf_valid_q,   buf_valid_d;
    logic [31:0] buf_target_q,  buf_target_d;
    logic        buf_wait_ds_q, buf_wait_ds_d;

    logic        occupied;
    logic        fs_allowin;
    logic        issue;
    logic        addr_acc;
    logic        data_acc;
    logic        br_capture;
    npc_sel_e    npc_sel;
    logic [31:0] nextpc;

    assign occupied   = fs_valid_q | fs_waiting_q;
    assign fs_allowin = ~occupied | (fs_valid_q & ds_allowin);
    // A stalled branch with its delay slot in IF must not let a sequential fetch slip out.
    assign issue      = ~req_q & fs_allowin & ~(br_stall & occupied);
    assign addr_acc   = req_q & inst_sram_addr_ok;
    assign data_acc   = fs_waiting_q & inst_sram_data_ok;

    // Pre-IF: next fetch address
    always_comb begin
        npc_sel = NpcSeq;
        nextpc  = seq_pc_q;
        if (buf_valid_q && !buf_wait_ds_q) begin
            npc_sel = NpcBrBuf;
            nextpc  = buf_target_q;
        end else if (br_taken && !br_stall && occupied) begin
            // Delay slot already in IF, so the target can go straight out.
            npc_sel = NpcBrTarget;
            nextpc  = br_target;
        end
    end

    // The branch leaves decode; remember its target unless it is issued right now.
    assign br_capture = br_taken & ~br_stall & ds_allowin &
                        ~(issue & (npc_sel == NpcBrTarget));

    always_comb begin
        req_d         = req_q;
        req_pc_d      = req_pc_q;
        seq_pc_d      = seq_pc_q;
        fs_pc_d       = fs_pc_q;
        fs_valid_d    = fs_valid_q;
        fs_waiting_d  = fs_waiting_q;
        fs_inst_d     = fs_inst_q;
        buf_valid_d   = buf_valid_q;
        buf_target_d  = buf_target_q;
        buf_wait_ds_d = buf_wait_ds_q;

        if (issue) begin
            req_d    = 1'b1;
            req_pc_d = nextpc;
        end

        if (addr_acc) begin
            req_d        = 1'b0;
            fs_pc_d      = req_pc_q;
            seq_pc_d     = req_pc_q + 32'd4;
            fs_waiting_d = 1'b1;
            fs_valid_d   = 1'b0;
            if (buf_wait_ds_q) begin
                buf_wait_ds_d = 1'b0;
            end else if (buf_valid_q && (req_pc_q == buf_target_q)) begin
                buf_valid_d = 1'b0;
            end
        end

        // Returned data always lands in the holding register, even if decode is blocked.
        if (data_acc) begin
            fs_waiting_d = 1'b0;
            fs_valid_d   = 1'b1;
            fs_inst_d    = inst_sram_rdata;
        end else if (fs_valid_q && ds_allowin) begin
            fs_valid_d = 1'b0;
        end

        if (br_capture) begin
            buf_valid_d   = 1'b1;
            buf_target_d  = br_target;
            // The delay slot is still unfetched unless IF holds it or it is accepted now.
            buf_wait_ds_d = ~(occupied | addr_acc);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q         <= 1'b0;
            req_pc_q      <= RESET_PC;
            seq_pc_q      <= RESET_PC;
            fs_pc_q       <= RESET_PC - 32'd4;
            fs_valid_q    <= 1'b0;
            fs_waiting_q  <= 1'b0;
            fs_inst_q     <= 32'd0;
            buf_valid_q   <= 1'b0;
            buf_target_q  <= 32'd0;
            buf_wait_ds_q <= 1'b0;
        end else begin
            req_q         <= req_d;
            req_pc_q      <= req_pc_d;
            seq_pc_q      <= seq_pc_d;
            fs_pc_q       <= fs_pc_d;
            fs_valid_q    <= fs_valid_d;
            fs_waiting_q  <= fs_waiting_d;
            fs_inst_q     <= fs_inst_d;
            buf_valid_q   <= buf_valid_d;
            buf_target_q  <= buf_target_d;
            buf_wait_ds_q <= buf_wait_ds_d;
        end
    end

    assign fs_to_ds_valid  = fs_valid_q;
    // Decode computes branch targets from this pc, so it shows the delay-slot pc when IF is empty.
    assign fs_to_ds_bus    = {fs_inst_q, (occupied ? fs_pc_q : seq_pc_q)};

    assign inst_sram_req   = req_q;
    assign inst_sram_addr  = req_pc_q;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'd0;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_allowin;
    logic [33:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    int n_pass  = 0;
    int n_total = 0;

    if_stage u_dut (
        .clk               (clk),
        .reset             (reset),
        .ds_allowin        (ds_allowin),
        .br_bus            (br_bus),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expects a pending request at address a; grants addr_ok, then data_ok one cycle later.
    task automatic fetch(input logic [31:0] a, input logic [31:0] inst);
        chk("req_up", {63'd0, inst_sram_req}, 64'd1);
        chk("req_addr", {32'd0, inst_sram_addr}, {32'd0, a});
        inst_sram_addr_ok = 1'b1;
        tick();
        inst_sram_addr_ok = 1'b0;
        chk("req_drop", {63'd0, inst_sram_req}, 64'd0);
        chk("wait_valid", {63'd0, fs_to_ds_valid}, 64'd0);
        chk("wait_pc", {32'd0, fs_to_ds_bus[31:0]}, {32'd0, a});
        inst_sram_rdata   = inst;
        inst_sram_data_ok = 1'b1;
        tick();
        inst_sram_data_ok = 1'b0;
        chk("data_valid", {63'd0, fs_to_ds_valid}, 64'd1);
        chk("data_bus", fs_to_ds_bus, {inst, a});
    endtask

    initial begin
        reset             = 1'b1;
        ds_allowin        = 1'b1;
        br_bus            = 34'd0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'd0;
        tick();
        tick();

        // Reset state
        chk("rst_req", {63'd0, inst_sram_req}, 64'd0);
        chk("rst_valid", {63'd0, fs_to_ds_valid}, 64'd0);
        chk("rst_pc", {32'd0, fs_to_ds_bus[31:0]}, 64'h0000_0000_BFC0_0000);
        chk("const_port", {25'd0, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
            {25'd0, 1'b0, 2'b10, 4'b0000, 32'd0});

        // Sequential stream
        reset = 1'b0;
        tick();
        fetch(32'hBFC0_0000, 32'h1111_0000);
        tick();
        chk("handoff", {63'd0, fs_to_ds_valid}, 64'd0);
        fetch(32'hBFC0_0004, 32'h1111_0004);
        tick();
        fetch(32'hBFC0_0008, 32'h1111_0008);

        // Decode blocked: instruction held, no new request
        ds_allowin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("blk_req", {63'd0, inst_sram_req}, 64'd0);
            chk("blk_bus", fs_to_ds_bus, 64'h1111_0008_BFC0_0008);
        end
        ds_allowin = 1'b1;
        tick();
        chk("unblk", {63'd0, fs_to_ds_valid}, 64'd0);
        fetch(32'hBFC0_000C, 32'h1111_000C);
        tick();
        fetch(32'hBFC0_0010, 32'h1000_00BB);    // branch
        tick();
        fetch(32'hBFC0_0014, 32'h1111_0014);    // delay slot, branch now in decode

        // Taken branch with delay slot in IF: target goes out directly
        br_bus = {1'b0, 1'b1, 32'hBFC0_0100};
        tick();
        br_bus = 34'd0;
        chk("tgt_valid", {63'd0, fs_to_ds_valid}, 64'd0);
        fetch(32'hBFC0_0100, 32'h2222_0100);
        tick();
        fetch(32'hBFC0_0104, 32'h1000_00CC);    // branch at BFC00104
        tick();

        // Branch leaves decode while IF is empty: delay slot first, then buffered target
        chk("empty_pc", {32'd0, fs_to_ds_bus[31:0]}, 64'h0000_0000_BFC0_0108);
        br_bus = {1'b0, 1'b1, 32'hBFC0_0200};
        tick();
        br_bus = 34'd0;
        chk("ds_addr", {32'd0, inst_sram_addr}, 64'h0000_0000_BFC0_0108);
        chk("ds_pc", {32'd0, fs_to_ds_bus[31:0]}, 64'h0000_0000_BFC0_0108);
        fetch(32'hBFC0_0108, 32'h1111_0108);
        tick();
        fetch(32'hBFC0_0200, 32'h3333_0200);
        tick();
        fetch(32'hBFC0_0204, 32'h1111_0204);

        // Stalled branch with IF occupied
        ds_allowin = 1'b0;
        br_bus     = {1'b1, 1'b1, 32'hBFC0_0300};
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_req", {63'd0, inst_sram_req}, 64'd0);
            chk("stall_valid", {63'd0, fs_to_ds_valid}, 64'd1);
        end
        br_bus     = {1'b0, 1'b1, 32'hBFC0_0300};
        ds_allowin = 1'b1;
        tick();
        br_bus = 34'd0;
        fetch(32'hBFC0_0300, 32'h4444_0300);
        tick();

        // addr_ok delayed while a branch appears: request held constant
        br_bus = {1'b0, 1'b1, 32'hBFC0_0400};
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_req", {63'd0, inst_sram_req}, 64'd1);
            chk("hold_addr", {32'd0, inst_sram_addr}, 64'h0000_0000_BFC0_0304);
        end
        br_bus = 34'd0;

        // Reset mid-wait
        reset = 1'b1;
        tick();
        chk("mid_rst_req", {63'd0, inst_sram_req}, 64'd0);
        chk("mid_rst_valid", {63'd0, fs_to_ds_valid}, 64'd0);
        chk("mid_rst_pc", {32'd0, fs_to_ds_bus[31:0]}, 64'h0000_0000_BFC0_0000);
        reset = 1'b0;
        tick();
        fetch(32'hBFC0_0000, 32'h5555_0000);
        tick();
        chk("post_rst_addr", {32'd0, inst_sram_addr}, 64'h0000_0000_BFC0_0004);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
